// File: rtl/mem_arbiter_pkg.sv
// Shared types for the instruction/data memory arbiter: core stages, access sizes,
// arbiter FSM states and the latched memory command.
package mem_arbiter_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned SIZE_W = 2;
  localparam int unsigned CNT_W  = 8;

  typedef enum logic [2:0] {
    STG_IF  = 3'd0,
    STG_ID  = 3'd1,
    STG_EX  = 3'd2,
    STG_MEM = 3'd3,
    STG_WB  = 3'd4
  } core_stage_e;

  typedef enum logic [SIZE_W-1:0] {
    SIZE_BYTE = 2'd0,
    SIZE_HALF = 2'd1,
    SIZE_WORD = 2'd2
  } mem_size_e;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_GNT_I = 2'd1,
    ARB_GNT_D = 2'd2
  } arb_state_e;

  typedef struct packed {
    logic              we;
    logic [SIZE_W-1:0] size;
    logic [XLEN-1:0]   addr;
    logic [XLEN-1:0]   wdata;
  } mem_cmd_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Core-side fetch/data ports and single-port memory bus seen by mem_arbiter.
interface mem_arbiter_if;
  import mem_arbiter_pkg::*;

  logic              i_req;
  logic [XLEN-1:0]   i_addr;
  logic              i_done;
  logic [XLEN-1:0]   i_rdata;

  logic              d_req;
  logic              d_we;
  logic [XLEN-1:0]   d_addr;
  logic [XLEN-1:0]   d_wdata;
  logic [SIZE_W-1:0] d_size;
  logic              d_done;
  logic [XLEN-1:0]   d_rdata;

  logic              err;

  logic              mem_req;
  logic              mem_we;
  logic [XLEN-1:0]   mem_addr;
  logic [XLEN-1:0]   mem_wdata;
  logic [SIZE_W-1:0] mem_size;
  logic              mem_ready;
  logic [XLEN-1:0]   mem_rdata;

  modport master (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, d_size, mem_ready, mem_rdata,
    output i_done, i_rdata, d_done, d_rdata, err,
           mem_req, mem_we, mem_addr, mem_wdata, mem_size
  );

  modport slave (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata, d_size, mem_ready, mem_rdata,
    input  i_done, i_rdata, d_done, d_rdata, err,
           mem_req, mem_we, mem_addr, mem_wdata, mem_size
  );

endinterface

// File: rtl/mem_arbiter_timer.sv
// Grant-state cycle counter; o_expired_c flags the last allowed wait cycle.
module mem_arb_timer
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expired_c
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_cnt <= '0;
    end else if (i_en && !o_expired_c) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign o_expired_c = i_en && (r_cnt == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates instruction fetch and data access onto one single-port memory.
// Define MEM_ARBITER_RR_EN for round-robin on simultaneous requests (default: D priority).
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic          clk,
  input  logic          rst,
  mem_arbiter_if.master bus
);

  arb_state_e      r_state;
  arb_state_e      w_state_nxt;
  mem_cmd_t        r_cmd;
  mem_cmd_t        w_cmd_i;
  mem_cmd_t        w_cmd_d;
  logic            r_mem_req;
  logic            r_i_done;
  logic            r_d_done;
  logic            r_err;
  logic [XLEN-1:0] r_i_rdata;
  logic [XLEN-1:0] r_d_rdata;

  logic w_i_ok;
  logic w_d_ok;
  logic w_pick_i;
  logic w_pick_d;
  logic w_grant_i;
  logic w_grant_d;
  logic w_finish;
  logic w_tmo;
  logic w_tmr_en;
  logic w_expired_c;

  // A requester still holds its request during its own done cycle; ignore it then.
  assign w_i_ok = bus.i_req && !r_i_done;
  assign w_d_ok = bus.d_req && !r_d_done;

`ifdef MEM_ARBITER_RR_EN
  logic r_last_d;

  assign w_pick_d = w_d_ok && (!w_i_ok || !r_last_d);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_last_d <= 1'b0;
    end else if (w_grant_d) begin
      r_last_d <= 1'b1;
    end else if (w_grant_i) begin
      r_last_d <= 1'b0;
    end
  end
`else
  assign w_pick_d = w_d_ok;
`endif

  assign w_pick_i = w_i_ok && !w_pick_d;

  assign w_cmd_i = mem_cmd_t'{we: 1'b0, size: SIZE_WORD, addr: bus.i_addr, wdata: '0};
  assign w_cmd_d = mem_cmd_t'{we: bus.d_we, size: bus.d_size, addr: bus.d_addr,
                              wdata: bus.d_wdata};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ARB_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_grant_i   = 1'b0;
    w_grant_d   = 1'b0;
    w_finish    = 1'b0;
    w_tmo       = 1'b0;
    case (r_state)
      ARB_IDLE: begin
        if (w_pick_d) begin
          w_state_nxt = ARB_GNT_D;
          w_grant_d   = 1'b1;
        end else if (w_pick_i) begin
          w_state_nxt = ARB_GNT_I;
          w_grant_i   = 1'b1;
        end
      end
      ARB_GNT_I, ARB_GNT_D: begin
        // A ready arriving on the last allowed cycle still completes normally.
        if (bus.mem_ready) begin
          w_state_nxt = ARB_IDLE;
          w_finish    = 1'b1;
        end else if (w_expired_c) begin
          w_state_nxt = ARB_IDLE;
          w_finish    = 1'b1;
          w_tmo       = 1'b1;
        end
      end
      default: w_state_nxt = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_mem_req <= 1'b0;
      r_cmd     <= '0;
      r_i_done  <= 1'b0;
      r_d_done  <= 1'b0;
      r_err     <= 1'b0;
      r_i_rdata <= '0;
      r_d_rdata <= '0;
    end else begin
      r_i_done <= 1'b0;
      r_d_done <= 1'b0;
      r_err    <= 1'b0;
      if (w_grant_d) begin
        r_mem_req <= 1'b1;
        r_cmd     <= w_cmd_d;
      end else if (w_grant_i) begin
        r_mem_req <= 1'b1;
        r_cmd     <= w_cmd_i;
      end
      if (w_finish) begin
        r_mem_req <= 1'b0;
        r_err     <= w_tmo;
        if (r_state == ARB_GNT_I) begin
          r_i_done  <= 1'b1;
          r_i_rdata <= w_tmo ? '0 : bus.mem_rdata;
        end else begin
          r_d_done  <= 1'b1;
          r_d_rdata <= w_tmo ? '0 : bus.mem_rdata;
        end
      end
    end
  end

  assign w_tmr_en = (r_state != ARB_IDLE);

  mem_arb_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clk         (clk),
    .rst         (rst),
    .i_clr       (!w_tmr_en),
    .i_en        (w_tmr_en),
    .o_expired_c (w_expired_c)
  );

  assign bus.mem_req   = r_mem_req;
  assign bus.mem_we    = r_cmd.we;
  assign bus.mem_size  = r_cmd.size;
  assign bus.mem_addr  = r_cmd.addr;
  assign bus.mem_wdata = r_cmd.wdata;
  assign bus.i_done    = r_i_done;
  assign bus.i_rdata   = r_i_rdata;
  assign bus.d_done    = r_d_done;
  assign bus.d_rdata   = r_d_rdata;
  assign bus.err       = r_err;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed and randomized transactions scored
// against a transaction-level timing model.
module tb_mem_arbiter;

  localparam int unsigned TMO = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk  = 0;
  int   n_fail = 0;
`ifdef MEM_ARBITER_RR_EN
  bit   last_d_m = 1'b0;
`endif

  mem_arbiter_if bus ();

  mem_arbiter #(
    .TIMEOUT (TMO)
  ) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %h expected %h", tag, $time, got, exp);
    end
  endtask

  task automatic check_quiet(input string tag);
    check_eq({tag, "_mem_req"}, 32'(bus.mem_req), 32'd0);
    check_eq({tag, "_i_done"}, 32'(bus.i_done), 32'd0);
    check_eq({tag, "_d_done"}, 32'(bus.d_done), 32'd0);
    check_eq({tag, "_err"}, 32'(bus.err), 32'd0);
  endtask

  // kind: 1 = fetch only, 2 = data only, 3 = both together.
  // dly = cycles mem_req is high before mem_ready rises; >= TMO means never.
  task automatic run_scn(input int kind, input logic [31:0] ia, input logic [31:0] da,
                         input logic [31:0] dw, input logic dwe, input logic [1:0] dsz,
                         input int dly0, input int dly1, input logic [31:0] rd0,
                         input logic [31:0] rd1, input bit drop);
    int n;
    bit is_d[2];
    int dly[2];
    logic [31:0] rd[2];
    int st[2];
    int mm[2];
    int dn[2];
    int last_t;
    dly[0] = dly0;
    dly[1] = dly1;
    rd[0]  = rd0;
    rd[1]  = rd1;
    n = (kind == 3) ? 2 : 1;
    if (kind == 1) is_d[0] = 1'b0;
    else if (kind == 2) is_d[0] = 1'b1;
    else begin
`ifdef MEM_ARBITER_RR_EN
      is_d[0] = !last_d_m;
`else
      is_d[0] = 1'b1;
`endif
    end
    is_d[1] = !is_d[0];
    for (int k = 0; k < n; k++) begin
      st[k] = (k == 0) ? 0 : dn[k-1];
      mm[k] = (dly[k] + 1 < int'(TMO)) ? dly[k] + 1 : int'(TMO);
      dn[k] = st[k] + mm[k] + 1;
`ifdef MEM_ARBITER_RR_EN
      last_d_m = is_d[k];
`endif
    end
    last_t = dn[n-1] + 1;

    for (int t = 0; t <= last_t; t++) begin
      bit exp_req;
      bit exp_id;
      bit exp_dd;
      bit exp_err;
      int kw;
      @(negedge clk);
      exp_req = 1'b0;
      exp_id  = 1'b0;
      exp_dd  = 1'b0;
      exp_err = 1'b0;
      kw = 0;
      for (int k = 0; k < n; k++) begin
        if (t >= st[k] + 1 && t <= st[k] + mm[k]) begin
          exp_req = 1'b1;
          kw = k;
        end
      end
      check_eq("mem_req", 32'(bus.mem_req), 32'(exp_req));
      if (exp_req) begin
        check_eq("mem_addr", bus.mem_addr, is_d[kw] ? da : ia);
        check_eq("mem_we", 32'(bus.mem_we), is_d[kw] ? 32'(dwe) : 32'd0);
        check_eq("mem_size", 32'(bus.mem_size), is_d[kw] ? 32'(dsz) : 32'd2);
        if (is_d[kw]) check_eq("mem_wdata", bus.mem_wdata, dw);
      end
      for (int k = 0; k < n; k++) begin
        if (t == dn[k]) begin
          exp_err = (dly[k] >= int'(TMO));
          if (is_d[k]) begin
            exp_dd = 1'b1;
            check_eq("d_rdata", bus.d_rdata, exp_err ? 32'd0 : rd[k]);
          end else begin
            exp_id = 1'b1;
            check_eq("i_rdata", bus.i_rdata, exp_err ? 32'd0 : rd[k]);
          end
        end
      end
      check_eq("i_done", 32'(bus.i_done), 32'(exp_id));
      check_eq("d_done", 32'(bus.d_done), 32'(exp_dd));
      check_eq("err", 32'(bus.err), 32'(exp_err));
      check_eq("done_excl", 32'(bus.i_done & bus.d_done), 32'd0);

      if (t == 0) begin
        bus.i_req   = (kind != 2);
        bus.d_req   = (kind != 1);
        bus.i_addr  = ia;
        bus.d_addr  = da;
        bus.d_wdata = dw;
        bus.d_we    = dwe;
        bus.d_size  = dsz;
      end
      for (int k = 0; k < n; k++) begin
        if (t == st[k] + 1) begin
          if (is_d[k]) begin
            bus.d_addr  = $urandom;
            bus.d_wdata = $urandom;
            bus.d_we    = 1'($urandom_range(0, 1));
            bus.d_size  = 2'($urandom_range(0, 2));
          end else begin
            bus.i_addr = $urandom;
          end
        end
        if (t == ((k == 0 && drop) ? 1 : dn[k] + 1)) begin
          if (is_d[k]) bus.d_req = 1'b0;
          else bus.i_req = 1'b0;
        end
      end
      if (exp_req) begin
        bus.mem_ready = (t == st[kw] + 1 + dly[kw]);
        bus.mem_rdata = rd[kw];
      end else begin
        bus.mem_ready = 1'($urandom_range(0, 1));
        bus.mem_rdata = $urandom;
      end
    end
  endtask

  task automatic reset_mid();
    @(negedge clk);
    check_quiet("rm_pre");
    bus.d_req     = 1'b1;
    bus.d_we      = 1'b1;
    bus.d_addr    = 32'h0000_0300;
    bus.d_wdata   = 32'h1234_5678;
    bus.d_size    = 2'd2;
    bus.mem_ready = 1'b0;
    @(negedge clk);
    check_eq("rm_req1", 32'(bus.mem_req), 32'd1);
    @(negedge clk);
    check_eq("rm_req2", 32'(bus.mem_req), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check_eq("rm_req_drop", 32'(bus.mem_req), 32'd0);
    check_eq("rm_d_done", 32'(bus.d_done), 32'd0);
    check_eq("rm_d_rdata", bus.d_rdata, 32'd0);
    check_eq("rm_i_rdata", bus.i_rdata, 32'd0);
    rst       = 1'b0;
    bus.d_req = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check_quiet("rm_post");
    end
`ifdef MEM_ARBITER_RR_EN
    last_d_m = 1'b0;
`endif
  endtask

  initial begin
    bus.i_req     = 1'b0;
    bus.i_addr    = '0;
    bus.d_req     = 1'b0;
    bus.d_we      = 1'b0;
    bus.d_addr    = '0;
    bus.d_wdata   = '0;
    bus.d_size    = '0;
    bus.mem_ready = 1'b0;
    bus.mem_rdata = '0;
    repeat (3) @(negedge clk);
    check_quiet("rst");
    check_eq("rst_i_rdata", bus.i_rdata, 32'd0);
    check_eq("rst_d_rdata", bus.d_rdata, 32'd0);
    check_eq("rst_mem_addr", bus.mem_addr, 32'd0);
    check_eq("rst_mem_we", 32'(bus.mem_we), 32'd0);
    rst = 1'b0;

    run_scn(1, 32'h0000_0100, 32'h0, 32'h0, 1'b0, 2'd2, 0, 0, 32'h0000_0013, 32'h0, 1'b0);
    run_scn(3, 32'h0000_0104, 32'h0000_0400, 32'h0, 1'b0, 2'd2, 1, 0,
            32'hAAAA_0001, 32'hBBBB_0002, 1'b0);
    run_scn(2, 32'h0, 32'h0000_0200, 32'hDEAD_BEEF, 1'b1, 2'd0, 3, 0,
            32'h5555_5555, 32'h0, 1'b0);
    run_scn(2, 32'h0, 32'h0000_0204, 32'h0, 1'b0, 2'd1, 20, 0, 32'h7777_7777, 32'h0, 1'b0);
    run_scn(1, 32'h0000_0108, 32'h0, 32'h0, 1'b0, 2'd2, TMO - 1, 0,
            32'h0BAD_F00D, 32'h0, 1'b1);

    for (int i = 0; i < 40; i++) begin
      run_scn($urandom_range(1, 3), $urandom, $urandom, $urandom, 1'($urandom_range(0, 1)),
              2'($urandom_range(0, 2)), $urandom_range(0, 6), $urandom_range(0, 6),
              $urandom, $urandom, ($urandom_range(0, 3) == 0));
      repeat ($urandom_range(0, 2)) begin
        @(negedge clk);
        check_quiet("gap");
        bus.mem_ready = 1'($urandom_range(0, 1));
      end
    end

    reset_mid();
    run_scn(1, 32'h0000_0110, 32'h0, 32'h0, 1'b0, 2'd2, 0, 0, 32'h0000_0093, 32'h0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      run_scn(3, $urandom, $urandom, $urandom, 1'b1, 2'd2, 0, 1, $urandom, $urandom, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
